// File: rtl/booth_seq_pkg.sv
// Shared types and constants for the Booth multiplier handshake sequencer.
package booth_seq_pkg;

  localparam int W_DEF              = 8;
  localparam int CAPTURE_CYCLES_DEF = 9;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  // Bit pattern of the most negative w-bit two's-complement value.
  function automatic logic [31:0] min_neg(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/booth_mult_sequencer.sv
// Valid/ready front-end for the sequential Booth multiplier: loads operands,
// waits out the compute latency, and holds the product in a one-entry result register.
module booth_mult_sequencer
  import booth_seq_pkg::*;
#(
  parameter int W              = W_DEF,
  parameter int CAPTURE_CYCLES = CAPTURE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [W-1:0]   in_a,
  input  logic signed [W-1:0]   in_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic signed [2*W-1:0] res_prod,
  output logic                  res_err,
  output logic [W-1:0]          mul_a,
  output logic [W-1:0]          mul_b,
  output logic                  mul_load,
  output logic                  mul_reset,
  input  logic [2*W-1:0]        mul_out
);

  localparam logic [W-1:0] MIN_NEG  = W'(min_neg(W));
  localparam logic [3:0]   CNT_INIT = 4'(CAPTURE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic             lat_err;
  logic [2*W-1:0]   cap_prod;
  logic             cap_err;
  logic             accept, capture, res_write;

  assign in_ready = (state == IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    res_write = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        accept    = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: state_nxt = RUN;
      RUN: if (cnt == 4'd0) begin
        capture   = 1'b1;
        state_nxt = DONE;
      end
      DONE: if (!res_valid || res_ready) begin
        res_write = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mul_a     <= '0;
      mul_b     <= '0;
      lat_err   <= 1'b0;
      mul_load  <= 1'b0;
      mul_reset <= 1'b1;
      cap_prod  <= '0;
      cap_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      mul_load  <= accept;
      // Held high through reset so the multiplier resynchronises on the first live edge.
      mul_reset <= 1'b0;
      if (accept) begin
        mul_a   <= in_a;
        mul_b   <= in_b;
        lat_err <= (in_a == MIN_NEG);
      end
      if (state == LOAD)
        cnt <= CNT_INIT;
      else if (state == RUN && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (capture) begin
        cap_prod <= mul_out;
        cap_err  <= lat_err;
      end
    end
  end

  // A drain and a refill on the same edge keep res_valid high with the new entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_prod  <= '0;
      res_err   <= 1'b0;
    end else if (res_write) begin
      res_valid <= 1'b1;
      res_prod  <= cap_prod;
      res_err   <= cap_err;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: doc/booth_mult_sequencer.md
# booth_mult_sequencer

Handshake front-end for the team's 8-bit signed Booth multiplier. Accepts operand pairs on a valid/ready input stream, drives the multiplier's `load`/`reset` controls, and waits a fixed number of compute cycles. It then captures the 16-bit product into a one-entry output register presented on a valid/ready result stream. It sits directly upstream of the multiplier and also consumes its `out` bus, so the rest of the datapath never handles multiplier timing.

## Interface
- `CAPTURE_CYCLES`, default 9: posedges between the multiplier's load edge and the product capture edge (8 Booth steps + 1 settle); legal range 9..15.
- `W`, default 8: operand width; product width is 2*W.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: **asynchronous, active-low** reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: sequencer can accept; high only in IDLE.
- `in_a` in W, signed: multiplier operand a.
- `in_b` in W, signed: multiplicand b.
- `res_valid` out 1: result register full.
- `res_ready` in 1: consumer accepts result.
- `res_prod` out 2W, signed: captured product.
- `res_err` out 1: result unreliable; set when `in_a` was -2^(W-1).
- `mul_a` out W: to multiplier `a`.
- `mul_b` out W: to multiplier `b`.
- `mul_load` out 1: to multiplier `load`, active-high, registered.
- `mul_reset` out 1: to multiplier `reset`, active-high synchronous, registered.
- `mul_out` in 2W: from multiplier `out`.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch a, b and err = (a == -2^(W-1)), then go to LOAD.
  - LOAD: `mul_load`=1 for exactly one cycle, counter = CAPTURE_CYCLES-1, then go to RUN.
  - RUN: counter decrements each posedge. At counter 0, latch `mul_out` into the capture holding register, then go to DONE.
  - DONE: write the result register when it is empty or being drained this cycle (`res_valid`=0 or `res_ready`=1), then go to IDLE. Otherwise stall in DONE.
- `mul_a`/`mul_b` hold the latched operands from IDLE exit until the next accept. They are stable through LOAD and RUN.
- Result register: `res_valid` clears on `res_valid & res_ready` unless it is refilled on the same edge. A simultaneous drain and refill keeps `res_valid`=1 with the new data.
- Error case: the sequence still runs. `res_prod` is whatever the multiplier produced, and `res_err`=1. `res_err` travels with its product.
- `in_valid` is ignored outside IDLE. No operand buffering.

## Timing
- Reset (async assert) values:
  - state = IDLE; `in_ready`=1 after the first posedge with `reset` high (combinational from state, so 1 during reset too).
  - `res_valid`=0, `res_prod`=0, `res_err`=0.
  - `mul_a`=`mul_b`=0, `mul_load`=0.
  - `mul_reset`=1, which stays 1 until the first posedge after `reset` deasserts, then 0.
- Accept at posedge T0 puts the FSM in LOAD. `mul_load`=1 during T0..T1, so the multiplier loads at T1.
- Booth steps occur at posedges T1+1..T1+8. Capture happens at T1+CAPTURE_CYCLES (T0+10 by default).
- Result register is written at the next posedge (T0+11 default) when it is free. `res_valid` is high from then on.
- Minimum accept-to-accept spacing is CAPTURE_CYCLES+3 posedges (12 default) with no backpressure.
- Reset asserted mid-LOAD, RUN or DONE aborts the operation and drops any pending result. The multiplier is resynchronised by the `mul_reset` pulse.
- `res_ready` low only stalls the FSM in DONE. A captured product is never lost or overwritten.

## Structure
- Package `booth_seq_pkg`: state enum (IDLE, LOAD, RUN, DONE), default `W`, `CAPTURE_CYCLES`, and the min-negative constant helper.
- Single module. No sub-module; the multiplier is instantiated beside it at the next level up.
- The bench top instantiates `booth_mult_sequencer` and `booth_multiplier` connected through the `mul_*` ports.

## Test plan
- a=7, b=3, `res_ready`=1 -> `res_prod`=21, `res_err`=0, and `res_valid` rises exactly 11 posedges after the accept.
- a=-5, b=6 -> `res_prod`=-30 (0xFFE2). Also a=-4, b=-4 -> `res_prod`=16.
- a=-128, b=1 -> `res_err`=1 with its result, and the FSM returns to IDLE normally.
- Backpressure: `res_ready`=0 with two ops offered (3*4, then 2*5) -> the first result is held at 12, the FSM stalls in DONE, and `in_ready`=0. Raising `res_ready` drains 12, then 10 appears the next cycle.
- `reset` pulsed low during RUN -> all outputs return to reset values immediately and `mul_reset`=1 for one cycle after release. A following op 9*9 gives 81.
- Back-to-back ops with `in_valid` held high -> accepts are spaced 12 posedges apart and the results are in order with none dropped.
